mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arbiter.sv | 109 ++++++++++
 tb/tb_mem_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory arbiter: access owner, read-return state
// and the default starvation limit.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CPU  = 2'd1,
        LDR  = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_CPU = 2'd1,
        RD_LDR = 2'd2
    } rd_state_t;

    localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port data-memory arbiter between the CPU MEM stage and a loader/debug
// port. CPU has priority, but the loader is forced through after STARVE_LIMIT denials.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_re,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_stall,
    output logic [15:0] cpu_rdata,
    output logic        cpu_rvalid,
    input  logic        ldr_req,
    input  logic        ldr_we,
    input  logic [15:0] ldr_addr,
    input  logic [15:0] ldr_wdata,
    output logic        ldr_gnt,
    output logic [15:0] ldr_rdata,
    output logic        ldr_rvalid,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [15:0] mem_rdata
);

    localparam int            CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic            w_cpu_req;
    logic            w_cpu_rd;
    owner_t          w_owner;
    rd_state_t       r_rd_state;
    logic [CW-1:0]   r_starve_cnt;

    assign w_cpu_req = cpu_re | cpu_we;
    assign w_cpu_rd  = cpu_re & ~cpu_we;

    // Owner is forced to NONE while reset is held so every grant output is quiet.
    always_comb begin
        w_owner = NONE;
        if (!rst_n)
            w_owner = NONE;
        else if (ldr_req && (r_starve_cnt == LIMIT))
            w_owner = LDR;
        else if (w_cpu_req)
            w_owner = CPU;
        else if (ldr_req)
            w_owner = LDR;
    end

    always_comb begin
        mem_addr  = 16'd0;
        mem_wdata = 16'd0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        case (w_owner)
            CPU: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_re    = w_cpu_rd;
                mem_we    = cpu_we;
            end
            LDR: begin
                mem_addr  = ldr_addr;
                mem_wdata = ldr_wdata;
                mem_re    = ~ldr_we;
                mem_we    = ldr_we;
            end
            default: ;
        endcase
    end

    assign cpu_stall  = rst_n & w_cpu_req & (w_owner != CPU);
    assign ldr_gnt    = (w_owner == LDR);
    assign cpu_rvalid = (r_rd_state == RD_CPU);
    assign ldr_rvalid = (r_rd_state == RD_LDR);
    assign cpu_rdata  = mem_rdata;
    assign ldr_rdata  = mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (w_owner == LDR) begin
            r_starve_cnt <= '0;
        end else if (ldr_req && (w_owner == CPU) && (r_starve_cnt != LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + CW'(1);
        end
    end

    // Read-return tracker: remembers who owns the data arriving next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_state <= IDLE;
        end else begin
            if ((w_owner == CPU) && w_cpu_rd)
                r_rd_state <= RD_CPU;
            else if ((w_owner == LDR) && !ldr_we)
                r_rd_state <= RD_LDR;
            else
                r_rd_state <= IDLE;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_mem_arbiter;

    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_re, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        cpu_stall, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        ldr_req, ldr_we;
    logic [15:0] ldr_addr, ldr_wdata;
    logic        ldr_gnt, ldr_rvalid;
    logic [15:0] ldr_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_re, mem_we;

    int n_vec = 0;
    int n_err = 0;
    int m_starve = 0;   // consecutive denied loader cycles
    int m_pend   = 0;   // 0: no read returning, 1: CPU read returning, 2: loader read returning

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(ldr_gnt), .ldr_rdata(ldr_rdata), .ldr_rvalid(ldr_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int who_owns();
        if (!rst_n) return 0;
        if (ldr_req && m_starve == SL) return 2;
        if (cpu_re || cpu_we) return 1;
        if (ldr_req) return 2;
        return 0;
    endfunction

    task automatic idle_inputs();
        cpu_re = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
    endtask

    // Let combinational outputs settle, then compare every output with the model.
    task automatic settle();
        int own;
        logic [15:0] e_addr, e_wdata;
        logic e_re, e_we;
        #1;
        if (!rst_n) m_pend = 0;
        own = who_owns();
        e_addr = 0; e_wdata = 0; e_re = 0; e_we = 0;
        if (own == 1) begin
            e_addr = cpu_addr; e_wdata = cpu_wdata; e_we = cpu_we; e_re = cpu_re && !cpu_we;
        end else if (own == 2) begin
            e_addr = ldr_addr; e_wdata = ldr_wdata; e_we = ldr_we; e_re = !ldr_we;
        end
        chk("cpu_stall",  cpu_stall,  rst_n && (cpu_re || cpu_we) && own != 1);
        chk("ldr_gnt",    ldr_gnt,    own == 2);
        chk("mem_addr",   mem_addr,   e_addr);
        chk("mem_wdata",  mem_wdata,  e_wdata);
        chk("mem_re",     mem_re,     e_re);
        chk("mem_we",     mem_we,     e_we);
        chk("cpu_rvalid", cpu_rvalid, m_pend == 1);
        chk("ldr_rvalid", ldr_rvalid, m_pend == 2);
        chk("cpu_rdata",  cpu_rdata,  mem_rdata);
        chk("ldr_rdata",  ldr_rdata,  mem_rdata);
    endtask

    // Clock the DUT and the model together, returning at the next falling edge.
    task automatic adv();
        int own;
        @(posedge clk);
        own = who_owns();
        if (!rst_n) begin
            m_starve = 0;
            m_pend   = 0;
        end else begin
            if (own == 2) m_starve = 0;
            else if (own == 1 && ldr_req && m_starve < SL) m_starve++;
            if (own == 1 && cpu_re && !cpu_we) m_pend = 1;
            else if (own == 2 && !ldr_we) m_pend = 2;
            else m_pend = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset held with live requests: everything quiet.
        rst_n = 0;
        cpu_re = 1; cpu_we = 0; cpu_addr = 16'h1111; cpu_wdata = 16'h2222;
        ldr_req = 1; ldr_we = 1; ldr_addr = 16'h3333; ldr_wdata = 16'h4444;
        mem_rdata = 16'h5A5A;
        settle();
        chk("rst_stall", cpu_stall, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        adv();
        rst_n = 1;
        idle_inputs();
        settle();
        adv();

        // CPU-only read.
        cpu_re = 1; cpu_addr = 16'h0010;
        settle();
        chk("cpu_rd_mem_re", mem_re, 1'b1);
        chk("cpu_rd_addr", mem_addr, 16'h0010);
        chk("cpu_rd_stall", cpu_stall, 1'b0);
        adv();
        idle_inputs(); mem_rdata = 16'hBEEF;
        settle();
        chk("cpu_rd_rvalid", cpu_rvalid, 1'b1);
        chk("cpu_rd_data", cpu_rdata, 16'hBEEF);
        adv();

        // Contention: four CPU grants, loader forced on the fifth, CPU again on the sixth.
        cpu_we = 1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
        ldr_req = 1; ldr_we = 1; ldr_addr = 16'h0040; ldr_wdata = 16'h5678;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk("cont_gnt", ldr_gnt, i == 4);
            chk("cont_stall", cpu_stall, i == 4);
            chk("cont_addr", mem_addr, (i == 4) ? 16'h0040 : 16'h0020);
            adv();
        end
        idle_inputs();

        // Read+write together is a write with no read return.
        cpu_re = 1; cpu_we = 1; cpu_addr = 16'h0008; cpu_wdata = 16'h00AA;
        settle();
        chk("rw_mem_we", mem_we, 1'b1);
        chk("rw_mem_re", mem_re, 1'b0);
        adv();
        idle_inputs();
        settle();
        chk("rw_no_rvalid", cpu_rvalid, 1'b0);
        adv();

        // Alternating owners, back-to-back reads.
        cpu_re = 1; cpu_addr = 16'h0002; mem_rdata = 16'h0101;
        settle();
        adv();
        idle_inputs(); ldr_req = 1; ldr_addr = 16'h0004; mem_rdata = 16'h0202;
        settle();
        chk("alt_cpu_rv1", cpu_rvalid, 1'b1);
        chk("alt_ldr_gnt", ldr_gnt, 1'b1);
        adv();
        idle_inputs(); cpu_re = 1; cpu_addr = 16'h0006; mem_rdata = 16'h0303;
        settle();
        chk("alt_ldr_rv", ldr_rvalid, 1'b1);
        chk("alt_ldr_data", ldr_rdata, 16'h0303);
        adv();
        idle_inputs(); mem_rdata = 16'h0404;
        settle();
        chk("alt_cpu_rv2", cpu_rvalid, 1'b1);
        chk("alt_ldr_rv_off", ldr_rvalid, 1'b0);
        adv();

        // Reset arrives in the cycle a read is granted.
        cpu_re = 1; cpu_addr = 16'h0030;
        settle();
        rst_n = 0;
        settle();
        chk("midrst_mem_re", mem_re, 1'b0);
        adv();
        rst_n = 1;
        idle_inputs();
        settle();
        chk("midrst_no_rv", cpu_rvalid, 1'b0);
        adv();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cpu_re    = ($urandom_range(0, 9) < 5);
            cpu_we    = ($urandom_range(0, 9) < 3);
            cpu_addr  = 16'($urandom);
            cpu_wdata = 16'($urandom);
            ldr_req   = ($urandom_range(0, 9) < 5);
            ldr_we    = $urandom_range(0, 1) == 1;
            ldr_addr  = 16'($urandom);
            ldr_wdata = 16'($urandom);
            mem_rdata = 16'($urandom);
            if (i == 200) rst_n = 0;
            if (i == 202) rst_n = 1;
            settle();
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
